// File: rtl/cmp_pkg.sv
// Shared compare-unit definitions: function codes, result codes, code encoder
// and the pipeline depth legality macro.
`ifndef CMP_PKG_SV
`define CMP_PKG_SV

// Legal pipeline depths are 1..4
`define CMP_PIPE_STAGES_OK(n) (((n) >= 1) && ((n) <= 4))

package cmp_pkg;

    localparam int unsigned FUNC_W = 3;
    localparam int unsigned CODE_W = 3;

    // ALU compare function codes
    localparam logic [FUNC_W-1:0] CMP_NOP  = 3'b000;
    localparam logic [FUNC_W-1:0] CMP_EQ   = 3'b001;
    localparam logic [FUNC_W-1:0] CMP_GT   = 3'b010;
    localparam logic [FUNC_W-1:0] CMP_LT   = 3'b011;
    localparam logic [FUNC_W-1:0] CMP_GE   = 3'b100;
    localparam logic [FUNC_W-1:0] CMP_LE   = 3'b101;
    localparam logic [FUNC_W-1:0] CMP_NE   = 3'b110;
    localparam logic [FUNC_W-1:0] CMP_CMP3 = 3'b111;

    // Result codes
    localparam logic [CODE_W-1:0] RES_NONE = 3'd0;
    localparam logic [CODE_W-1:0] RES_EQ   = 3'd1;
    localparam logic [CODE_W-1:0] RES_GT   = 3'd2;
    localparam logic [CODE_W-1:0] RES_LT   = 3'd3;
    localparam logic [CODE_W-1:0] RES_GE   = 3'd4;
    localparam logic [CODE_W-1:0] RES_LE   = 3'd5;
    localparam logic [CODE_W-1:0] RES_NE   = 3'd6;

    // Map a function and the three primitive relations onto a result code
    function automatic logic [CODE_W-1:0] cmp_code(
        input logic [FUNC_W-1:0] func,
        input logic              eq,
        input logic              gt,
        input logic              lt
    );
        logic [CODE_W-1:0] code;
        code = RES_NONE;
        case (func)
            CMP_EQ:   code = eq        ? RES_EQ : RES_NONE;
            CMP_GT:   code = gt        ? RES_GT : RES_NONE;
            CMP_LT:   code = lt        ? RES_LT : RES_NONE;
            CMP_GE:   code = (gt | eq) ? RES_GE : RES_NONE;
            CMP_LE:   code = (lt | eq) ? RES_LE : RES_NONE;
            CMP_NE:   code = !eq       ? RES_NE : RES_NONE;
            CMP_CMP3: code = eq ? RES_EQ : (gt ? RES_GT : RES_LT);
            default:  code = RES_NONE;
        endcase
        return code;
    endfunction

endpackage

`endif

// File: rtl/cmp_pipe_stage.sv
// One pipeline stage: valid flag plus payload, advancing on enable, sync reset.
module cmp_pipe_stage
    import cmp_pkg::*;
#(
    parameter int unsigned W = 3
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // Capture the upstream beat when the pipe advances; bubbles carry a zero payload
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_en) begin
            r_valid <= i_valid;
            r_data  <= i_valid ? i_data : '0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/cmp_pipe_unit.sv
// Pipelined relational compare unit with valid/ready handshake and running
// min/max statistics of operand A.
// Optional feature macro: CMP_STICKY_EN adds the STICKY_HIT output.
module cmp_pipe_unit
    import cmp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned OUT_WIDTH   = 3,
    parameter int unsigned PIPE_STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [FUNC_W-1:0]     ALU_FUNC,
    input  logic                  SIGNED_MODE,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic                  OUT_READY,
    output logic [OUT_WIDTH-1:0]  CMP_OUT,
    output logic                  CMP_Flag,
    input  logic                  CLR_STATS,
    output logic [DATA_WIDTH-1:0] RUN_MIN,
    output logic [DATA_WIDTH-1:0] RUN_MAX,
    output logic                  STAT_VALID
`ifdef CMP_STICKY_EN
    ,
    output logic                  STICKY_HIT
`endif
);

    // Elaboration-time guard on the pipeline depth
    if (!`CMP_PIPE_STAGES_OK(PIPE_STAGES)) begin : g_bad_pipe_stages
        $error("cmp_pipe_unit: PIPE_STAGES must be within 1..4");
    end

    logic                                w_advance;
    logic                                w_accept;
    logic                                w_count;
    logic                                w_eq;
    logic                                w_lt;
    logic                                w_gt;
    logic [OUT_WIDTH-1:0]                w_code;
    logic [PIPE_STAGES:0]                w_vld;
    logic [PIPE_STAGES:0][OUT_WIDTH-1:0] w_pay;
    logic                                w_a_lt_min;
    logic                                w_a_gt_max;

    logic [DATA_WIDTH-1:0]               r_min;
    logic [DATA_WIDTH-1:0]               r_max;
    logic                                r_stat_valid;

    // Global stall: every stage moves only when the output slot is free or draining
    assign w_advance = !CMP_Flag || OUT_READY;
    assign IN_READY  = w_advance;
    assign w_accept  = IN_VALID && w_advance;
    assign w_count   = w_accept && (ALU_FUNC != CMP_NOP);

    // Primitive relations under the beat's signedness
    assign w_eq   = (A == B);
    assign w_lt   = SIGNED_MODE ? ($signed(A) < $signed(B)) : (A < B);
    assign w_gt   = !w_eq && !w_lt;
    assign w_code = OUT_WIDTH'(cmp_code(ALU_FUNC, w_eq, w_gt, w_lt));

    assign w_vld[0] = IN_VALID;
    assign w_pay[0] = w_code;

    // Stage 1 registers the compare result, later stages only delay it
    for (genvar g = 0; g < PIPE_STAGES; g++) begin : g_stage
        cmp_pipe_stage #(
            .W (OUT_WIDTH)
        ) u_stage (
            .i_clk   (CLK),
            .i_rst   (RST),
            .i_en    (w_advance),
            .i_valid (w_vld[g]),
            .i_data  (w_pay[g]),
            .o_valid (w_vld[g+1]),
            .o_data  (w_pay[g+1])
        );
    end

    assign CMP_Flag = w_vld[PIPE_STAGES];
    assign CMP_OUT  = w_pay[PIPE_STAGES];

    // Min/max relations of the incoming A against the running extremes
    assign w_a_lt_min = SIGNED_MODE ? ($signed(A) < $signed(r_min)) : (A < r_min);
    assign w_a_gt_max = SIGNED_MODE ? ($signed(A) > $signed(r_max)) : (A > r_max);

    // Running statistics: a clear coinciding with a counted beat reloads from that beat
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_min        <= '0;
            r_max        <= '0;
            r_stat_valid <= 1'b0;
        end else if (w_count) begin
            if (CLR_STATS || !r_stat_valid) begin
                r_min        <= A;
                r_max        <= A;
                r_stat_valid <= 1'b1;
            end else begin
                if (w_a_lt_min) r_min <= A;
                if (w_a_gt_max) r_max <= A;
            end
        end else if (CLR_STATS) begin
            r_min        <= '0;
            r_max        <= '0;
            r_stat_valid <= 1'b0;
        end
    end

    assign RUN_MIN    = r_min;
    assign RUN_MAX    = r_max;
    assign STAT_VALID = r_stat_valid;

`ifdef CMP_STICKY_EN
    logic r_sticky;

    // Remember any non-zero result handed downstream; clear dominates a simultaneous set
    always_ff @(posedge CLK) begin
        if (RST || CLR_STATS) begin
            r_sticky <= 1'b0;
        end else if (CMP_Flag && OUT_READY && (CMP_OUT != '0)) begin
            r_sticky <= 1'b1;
        end
    end

    assign STICKY_HIT = r_sticky;
`endif

endmodule

// File: tb/tb_cmp_pipe_unit.sv
// Directed, table-driven bench for cmp_pipe_unit (main instance PIPE_STAGES=2,
// extra instances at depths 1, 3, 4 for the latency sweep).
module tb_cmp_pipe_unit;

    localparam int unsigned DW = 16;
    localparam int unsigned OW = 3;

    logic          CLK;
    logic          RST;
    logic [DW-1:0] A;
    logic [DW-1:0] B;
    logic [2:0]    ALU_FUNC;
    logic          SIGNED_MODE;
    logic          IN_VALID;
    logic          OUT_READY;
    logic          CLR_STATS;

    logic          in_ready   [4];
    logic [OW-1:0] cmp_out    [4];
    logic          cmp_flag   [4];
    logic [DW-1:0] run_min    [4];
    logic [DW-1:0] run_max    [4];
    logic          stat_valid [4];
`ifdef CMP_STICKY_EN
    logic          sticky_hit [4];
`endif

    int n_chk  = 0;
    int n_fail = 0;

    // Instance k has PIPE_STAGES = k+1; instance 1 (depth 2) is the main DUT
    for (genvar k = 0; k < 4; k++) begin : g_dut
        cmp_pipe_unit #(
            .DATA_WIDTH  (DW),
            .OUT_WIDTH   (OW),
            .PIPE_STAGES (k + 1)
        ) u_dut (
            .CLK         (CLK),
            .RST         (RST),
            .A           (A),
            .B           (B),
            .ALU_FUNC    (ALU_FUNC),
            .SIGNED_MODE (SIGNED_MODE),
            .IN_VALID    (IN_VALID),
            .IN_READY    (in_ready[k]),
            .OUT_READY   (OUT_READY),
            .CMP_OUT     (cmp_out[k]),
            .CMP_Flag    (cmp_flag[k]),
            .CLR_STATS   (CLR_STATS),
            .RUN_MIN     (run_min[k]),
            .RUN_MAX     (run_max[k]),
            .STAT_VALID  (stat_valid[k])
`ifdef CMP_STICKY_EN
            ,
            .STICKY_HIT  (sticky_hit[k])
`endif
        );
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [2:0]    f;
        logic          sm;
        logic [OW-1:0] exp;
    } vec_t;

    localparam int NV = 16;
    vec_t vt [NV];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [2:0] f, input logic sm);
        IN_VALID    = v;
        A           = a;
        B           = b;
        ALU_FUNC    = f;
        SIGNED_MODE = sm;
    endtask

    task automatic do_reset();
        RST       = 1'b1;
        CLR_STATS = 1'b0;
        OUT_READY = 1'b1;
        drive(1'b0, '0, '0, 3'b000, 1'b0);
        tick();
        tick();
        RST = 1'b0;
    endtask

    logic [OW-1:0] bp_exp [8];

    initial begin
        RST = 1'b1; CLR_STATS = 1'b0; OUT_READY = 1'b1;
        drive(1'b0, '0, '0, 3'b000, 1'b0);

        // Vector table: {A, B, func, signed, expected code}
        vt[0]  = '{16'h8000, 16'h0001, 3'b011, 1'b1, 3'd3};
        vt[1]  = '{16'h8000, 16'h0001, 3'b011, 1'b0, 3'd0};
        vt[2]  = '{16'h00FF, 16'h00FF, 3'b111, 1'b1, 3'd1};
        vt[3]  = '{16'h0005, 16'h0003, 3'b010, 1'b0, 3'd2};
        vt[4]  = '{16'hFFFF, 16'h0001, 3'b010, 1'b1, 3'd0};
        vt[5]  = '{16'hFFFF, 16'h0001, 3'b010, 1'b0, 3'd2};
        vt[6]  = '{16'h0003, 16'h0003, 3'b100, 1'b0, 3'd4};
        vt[7]  = '{16'h0002, 16'h0003, 3'b101, 1'b0, 3'd5};
        vt[8]  = '{16'h0004, 16'h0003, 3'b101, 1'b0, 3'd0};
        vt[9]  = '{16'h1234, 16'h1235, 3'b110, 1'b0, 3'd6};
        vt[10] = '{16'h1234, 16'h1234, 3'b001, 1'b1, 3'd1};
        vt[11] = '{16'h1234, 16'h1234, 3'b110, 1'b0, 3'd0};
        vt[12] = '{16'h0000, 16'h0000, 3'b000, 1'b0, 3'd0};
        vt[13] = '{16'h8000, 16'h7FFF, 3'b111, 1'b1, 3'd3};
        vt[14] = '{16'h8000, 16'h7FFF, 3'b111, 1'b0, 3'd2};
        vt[15] = '{16'h7FFF, 16'h8000, 3'b100, 1'b1, 3'd4};

        bp_exp[0] = 3'd3; bp_exp[1] = 3'd3; bp_exp[2] = 3'd3; bp_exp[3] = 3'd1;
        bp_exp[4] = 3'd2; bp_exp[5] = 3'd2; bp_exp[6] = 3'd2; bp_exp[7] = 3'd2;

        // Reset held two cycles with a beat offered
        @(posedge CLK); #1;
        RST = 1'b1;
        drive(1'b1, 16'h0003, 16'h0001, 3'b010, 1'b0);
        tick();
        tick();
        RST = 1'b0;
        drive(1'b0, '0, '0, 3'b000, 1'b0);
        chk("rst_flag", 32'(cmp_flag[1]), 32'd0);
        chk("rst_code", 32'(cmp_out[1]), 32'd0);
        chk("rst_stat_valid", 32'(stat_valid[1]), 32'd0);
        chk("rst_min", 32'(run_min[1]), 32'd0);
        chk("rst_max", 32'(run_max[1]), 32'd0);
        chk("rst_in_ready", 32'(in_ready[1]), 32'd1);
        tick();
        chk("rst_flag_after", 32'(cmp_flag[1]), 32'd0);

        // Latency sweep: a single GT beat, flag must appear exactly at edge = depth
        drive(1'b1, 16'h0003, 16'h0001, 3'b010, 1'b0);
        for (int e = 1; e <= 4; e++) begin
            tick();
            drive(1'b0, '0, '0, 3'b000, 1'b0);
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("lat_d%0d_e%0d_flag", k + 1, e), 32'(cmp_flag[k]),
                    (e == k + 1) ? 32'd1 : 32'd0);
                if (e == k + 1)
                    chk($sformatf("lat_d%0d_code", k + 1), 32'(cmp_out[k]), 32'd2);
            end
        end

        // Table vectors streamed at full throughput through the depth-2 DUT
        do_reset();
        for (int i = 0; i <= NV; i++) begin
            if (i < NV) drive(1'b1, vt[i].a, vt[i].b, vt[i].f, vt[i].sm);
            else        drive(1'b0, '0, '0, 3'b000, 1'b0);
            tick();
            if (i >= 1) begin
                chk($sformatf("vec%0d_flag", i - 1), 32'(cmp_flag[1]), 32'd1);
                chk($sformatf("vec%0d_code", i - 1), 32'(cmp_out[1]), 32'(vt[i-1].exp));
            end
        end
        drive(1'b0, '0, '0, 3'b000, 1'b0);
        tick();
        chk("vec_drain_flag", 32'(cmp_flag[1]), 32'd0);

        // Backpressure: 8 CMP3 beats (A=i, B=3) with OUT_READY pattern 1,0,0,1
        do_reset();
        begin
            int            sent;
            int            rcvd;
            logic          hold_pend;
            logic [OW-1:0] hold_code;
            sent = 0; rcvd = 0; hold_pend = 1'b0; hold_code = '0;
            for (int c = 0; c < 100 && rcvd < 8; c++) begin
                OUT_READY = ((c % 4) == 0) || ((c % 4) == 3);
                if (sent < 8) drive(1'b1, DW'(sent), 16'h0003, 3'b111, 1'b0);
                else          drive(1'b0, '0, '0, 3'b000, 1'b0);
                @(negedge CLK);
                if (hold_pend) begin
                    chk("bp_hold_flag", 32'(cmp_flag[1]), 32'd1);
                    chk("bp_hold_code", 32'(cmp_out[1]), 32'(hold_code));
                end
                hold_pend = 1'b0;
                if (cmp_flag[1] && !OUT_READY) begin
                    chk("bp_stall_in_ready", 32'(in_ready[1]), 32'd0);
                    hold_pend = 1'b1;
                    hold_code = cmp_out[1];
                end
                if (cmp_flag[1] && OUT_READY) begin
                    if (rcvd < 8) chk($sformatf("bp_order%0d", rcvd), 32'(cmp_out[1]), 32'(bp_exp[rcvd]));
                    rcvd++;
                end
                if (IN_VALID && in_ready[1]) sent++;
                tick();
            end
            chk("bp_received", 32'(rcvd), 32'd8);
            chk("bp_sent", 32'(sent), 32'd8);
            OUT_READY = 1'b1;
            drive(1'b0, '0, '0, 3'b000, 1'b0);
            for (int c = 0; c < 3; c++) begin
                tick();
                chk("bp_no_duplicate", 32'(cmp_flag[1]), 32'd0);
            end
        end

        // Statistics: unsigned A = 5, 2, 9, NOP(0), 7
        do_reset();
        drive(1'b1, 16'd5, 16'd0, 3'b001, 1'b0);
        tick();
        chk("st_first_min", 32'(run_min[1]), 32'd5);
        chk("st_first_max", 32'(run_max[1]), 32'd5);
        chk("st_first_valid", 32'(stat_valid[1]), 32'd1);
        drive(1'b1, 16'd2, 16'd0, 3'b001, 1'b0); tick();
        drive(1'b1, 16'd9, 16'd0, 3'b001, 1'b0); tick();
        drive(1'b1, 16'd0, 16'd0, 3'b000, 1'b0); tick();
        drive(1'b1, 16'd7, 16'd0, 3'b001, 1'b0); tick();
        drive(1'b0, '0, '0, 3'b000, 1'b0);
        chk("st_min", 32'(run_min[1]), 32'd2);
        chk("st_max", 32'(run_max[1]), 32'd9);
        // Clear together with a beat of A=4
        CLR_STATS = 1'b1;
        drive(1'b1, 16'd4, 16'd0, 3'b001, 1'b0);
        tick();
        CLR_STATS = 1'b0;
        drive(1'b0, '0, '0, 3'b000, 1'b0);
        chk("st_clr_beat_min", 32'(run_min[1]), 32'd4);
        chk("st_clr_beat_max", 32'(run_max[1]), 32'd4);
        chk("st_clr_beat_valid", 32'(stat_valid[1]), 32'd1);
        // Clear alone
        CLR_STATS = 1'b1;
        tick();
        CLR_STATS = 1'b0;
        chk("st_clr_valid", 32'(stat_valid[1]), 32'd0);
        // Signed extremes: -1 then +1
        drive(1'b1, 16'hFFFF, 16'd0, 3'b001, 1'b1); tick();
        drive(1'b1, 16'h0001, 16'd0, 3'b001, 1'b1); tick();
        drive(1'b0, '0, '0, 3'b000, 1'b0);
        chk("st_signed_min", 32'(run_min[1]), 32'h0000FFFF);
        chk("st_signed_max", 32'(run_max[1]), 32'h00000001);

        // Reset mid-stream: two beats accepted, third offered under reset
        do_reset();
        drive(1'b1, 16'd1, 16'd1, 3'b001, 1'b0); tick();
        drive(1'b1, 16'd2, 16'd1, 3'b010, 1'b0); tick();
        RST = 1'b1;
        drive(1'b1, 16'd3, 16'd1, 3'b010, 1'b0); tick();
        RST = 1'b0;
        drive(1'b0, '0, '0, 3'b000, 1'b0);
        for (int c = 0; c < 5; c++) begin
            chk("mid_rst_no_flag", 32'(cmp_flag[1]), 32'd0);
            tick();
        end

`ifdef CMP_STICKY_EN
        // Sticky hit on a transferred non-zero result, cleared by CLR_STATS
        do_reset();
        chk("sticky_rst", 32'(sticky_hit[1]), 32'd0);
        drive(1'b1, 16'd3, 16'd1, 3'b010, 1'b0); tick();
        drive(1'b0, '0, '0, 3'b000, 1'b0);
        tick();
        chk("sticky_before_xfer", 32'(sticky_hit[1]), 32'd0);
        tick();
        chk("sticky_set", 32'(sticky_hit[1]), 32'd1);
        CLR_STATS = 1'b1;
        tick();
        CLR_STATS = 1'b0;
        chk("sticky_clr", 32'(sticky_hit[1]), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
